// File: rtl/mod10_pkg.sv
// Shared definitions for the mod-10 counter family: BCD limits, checker
// state encoding and the successor function.
package mod10_pkg;

    localparam int MOD10_MAX = 9;
    localparam int BCD_W     = 4;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

    function automatic logic [BCD_W-1:0] mod10_next(input logic [BCD_W-1:0] v);
        return (v == BCD_W'(MOD10_MAX)) ? '0 : v + BCD_W'(1);
    endfunction

endpackage

// File: rtl/mod10_seq_checker_sat_counter.sv
// Saturating up-counter: increments on inc and holds once it reaches all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mod10_seq_checker.sv
// Monitors a BCD count stream for the 0..9 cycle: locks after a run of
// correct steps, flags illegal codes and breaks, and counts decade wraps.
//
//   state     | meaning
//   ST_EMPTY  | no reference value held
//   ST_SYNC   | reference held, building a run of matches
//   ST_LOCKED | run complete, every sample must follow the previous one
module mod10_seq_checker
    import mod10_pkg::*;
#(
    parameter int LOCK_COUNT = 3,
    parameter int WRAP_W     = 8,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              q_valid,
    input  logic [BCD_W-1:0]  q_in,
    output logic              locked,
    output logic              wrap,
    output logic              err_seq,
    output logic              err_illegal,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    chk_state_t       state, state_nx;
    logic [BCD_W-1:0] expected, expected_nx;
    logic [3:0]       match_cnt, match_cnt_nx;
    logic             wrap_nx, err_seq_nx, err_illegal_nx;
    logic             hit;

    assign hit = (q_in == expected);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_EMPTY;
            expected    <= '0;
            match_cnt   <= '0;
            locked      <= 1'b0;
            wrap        <= 1'b0;
            err_seq     <= 1'b0;
            err_illegal <= 1'b0;
            wrap_cnt    <= '0;
        end else begin
            state       <= state_nx;
            expected    <= expected_nx;
            match_cnt   <= match_cnt_nx;
            locked      <= (state_nx == ST_LOCKED);
            wrap        <= wrap_nx;
            err_seq     <= err_seq_nx;
            err_illegal <= err_illegal_nx;
            if (wrap_nx) begin
                wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end
        end
    end

    always_comb begin
        state_nx       = state;
        expected_nx    = expected;
        match_cnt_nx   = match_cnt;
        wrap_nx        = 1'b0;
        err_seq_nx     = 1'b0;
        err_illegal_nx = 1'b0;

        if (q_valid) begin
            if (q_in > BCD_W'(MOD10_MAX)) begin
                // An illegal code discards the reference entirely.
                err_illegal_nx = 1'b1;
                state_nx       = ST_EMPTY;
                match_cnt_nx   = '0;
            end else begin
                expected_nx = mod10_next(q_in);
                case (state)
                    ST_EMPTY: begin
                        match_cnt_nx = '0;
                        state_nx     = ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (hit) begin
                            match_cnt_nx = match_cnt + 4'd1;
                            if ((match_cnt + 4'd1) == LOCK_N) begin
                                state_nx = ST_LOCKED;
                            end
                        end else begin
                            match_cnt_nx = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (hit) begin
                            wrap_nx = (q_in == '0);
                        end else begin
                            err_seq_nx   = 1'b1;
                            match_cnt_nx = '0;
                            state_nx     = ST_SYNC;
                        end
                    end
                    default: begin
                        state_nx     = ST_EMPTY;
                        match_cnt_nx = '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_seq_nx | err_illegal_nx),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_mod10_seq_checker.sv
// Bench for mod10_seq_checker: directed scenarios followed by random traffic,
// all checked against a behavioural model of the counting rules.
module tb_mod10_seq_checker;

    localparam int LOCK_COUNT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       q_valid = 1'b0;
    logic [3:0] q_in = 4'd0;

    logic       locked, wrap, err_seq, err_illegal;
    logic [7:0] wrap_cnt, err_cnt;
    logic       locked_s, wrap_s, err_seq_s, err_illegal_s;
    logic [7:0] wrap_cnt_s;
    logic [1:0] err_cnt_s;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit m_have_ref;
    int m_last;
    int m_run;
    bit m_locked, m_wrap, m_err_seq, m_err_ill;
    int m_wraps, m_errs;
    int cur;

    mod10_seq_checker #(.LOCK_COUNT(LOCK_COUNT), .WRAP_W(8), .ERR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .q_valid     (q_valid),
        .q_in        (q_in),
        .locked      (locked),
        .wrap        (wrap),
        .err_seq     (err_seq),
        .err_illegal (err_illegal),
        .wrap_cnt    (wrap_cnt),
        .err_cnt     (err_cnt)
    );

    mod10_seq_checker #(.LOCK_COUNT(LOCK_COUNT), .WRAP_W(8), .ERR_W(2)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .q_valid     (q_valid),
        .q_in        (q_in),
        .locked      (locked_s),
        .wrap        (wrap_s),
        .err_seq     (err_seq_s),
        .err_illegal (err_illegal_s),
        .wrap_cnt    (wrap_cnt_s),
        .err_cnt     (err_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have_ref = 0; m_last = 0; m_run = 0;
        m_locked = 0; m_wrap = 0; m_err_seq = 0; m_err_ill = 0;
        m_wraps = 0; m_errs = 0;
    endtask

    task automatic model_step(input bit v, input int q);
        m_wrap = 0; m_err_seq = 0; m_err_ill = 0;
        if (!v) return;
        if (q >= 10) begin
            m_err_ill = 1; m_errs++;
            m_have_ref = 0; m_run = 0; m_locked = 0;
        end else if (!m_have_ref) begin
            m_have_ref = 1; m_last = q; m_run = 0;
        end else begin
            if (q == (m_last + 1) % 10) begin
                if (m_locked) begin
                    if (q == 0) begin
                        m_wrap = 1; m_wraps++;
                    end
                end else begin
                    m_run++;
                    if (m_run >= LOCK_COUNT) m_locked = 1;
                end
            end else begin
                if (m_locked) begin
                    m_err_seq = 1; m_errs++; m_locked = 0;
                end
                m_run = 0;
            end
            m_last = q;
        end
    endtask

    task automatic compare_all();
        chk("locked",      int'(locked),      int'(m_locked));
        chk("wrap",        int'(wrap),        int'(m_wrap));
        chk("err_seq",     int'(err_seq),     int'(m_err_seq));
        chk("err_illegal", int'(err_illegal), int'(m_err_ill));
        chk("wrap_cnt",    int'(wrap_cnt),    m_wraps % 256);
        chk("err_cnt",     int'(err_cnt),     (m_errs > 255) ? 255 : m_errs);
        chk("err_cnt_sat", int'(err_cnt_s),   (m_errs > 3) ? 3 : m_errs);
        chk("err_ill_sat", int'(err_illegal_s), int'(m_err_ill));
    endtask

    task automatic do_cycle(input bit v, input int q);
        q_valid = v;
        q_in    = 4'(q);
        @(posedge clk);
        model_step(v, q);
        #1;
        compare_all();
    endtask

    task automatic feed_seq(input int start, input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b1, (start + i) % 10);
    endtask

    // Reset asserted between edges; outputs must clear before any clock.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_locked",   int'(locked),      0);
        chk("rst_wrap",     int'(wrap),        0);
        chk("rst_err_seq",  int'(err_seq),     0);
        chk("rst_err_ill",  int'(err_illegal), 0);
        chk("rst_wrap_cnt", int'(wrap_cnt),    0);
        chk("rst_err_cnt",  int'(err_cnt),     0);
        #9;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        compare_all();
        reset = 1'b0;

        // lock and wrap
        feed_seq(0, 12);
        chk("lock_wrap_cnt", int'(wrap_cnt), 1);
        // sequence break at 5 -> 7, then relock on 8,9,0 without a wrap
        feed_seq(2, 4);
        do_cycle(1'b1, 7);
        chk("break_locked", int'(locked), 0);
        feed_seq(8, 3);
        chk("relock", int'(locked), 1);
        chk("relock_no_wrap", int'(wrap_cnt), 1);
        // illegal code while locked, then seed and relock
        do_cycle(1'b1, 12);
        feed_seq(4, 4);
        // gaps between 6 and 7
        feed_seq(8, 9);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, $urandom_range(0, 15));
        do_cycle(1'b1, 7);
        chk("gap_locked", int'(locked), 1);
        // reset during count 4 while locked
        feed_seq(8, 7);
        mid_reset();
        do_cycle(1'b1, 5);
        // saturation of the narrow error counter
        for (int i = 0; i < 5; i++) do_cycle(1'b1, $urandom_range(10, 15));

        // long clean run to roll wrap_cnt over
        feed_seq(0, 2700);

        // random traffic
        cur = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                cur = (cur + 1) % 10;
                do_cycle(1'b1, cur);
            end else if (r < 82) begin
                do_cycle(1'b0, $urandom_range(0, 15));
            end else if (r < 92) begin
                cur = $urandom_range(0, 9);
                do_cycle(1'b1, cur);
            end else if (r < 99) begin
                do_cycle(1'b1, $urandom_range(10, 15));
            end else begin
                mid_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
